// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FPU_WAIT    = 2'd1,
        ST_FPU_RELEASE = 2'd2
    } hz_state_t;

    localparam int         FPU_LAT_DEFAULT = 4;
    localparam int         FPU_CNT_W       = 4;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    // A double-writing float op also owns dst+1, wrapping 31 -> 0.
    function automatic logic reg_match(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       pair
    );
        return (src == dst) || (pair && (src == (dst + 5'd1)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use compare between the ID sources and EX dest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic       i_id_float,
    input  logic       i_ex_load,
    input  logic       i_ex_rwrite,
    input  logic [4:0] i_ex_dst,
    input  logic       i_ex_float,
    input  logic       i_ex_dw,
    output logic       o_load_use
);

    logic w_pair;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_pair = i_ex_dw & i_ex_float;

    // Integer r0 is hardwired zero and never carries a dependency.
    assign w_rs_hit = reg_match(i_id_rs, i_ex_dst, w_pair)
                    & ~(~i_id_float & (i_id_rs == REG_ZERO));
    assign w_rt_hit = i_id_uses_rt
                    & reg_match(i_id_rt, i_ex_dst, w_pair)
                    & ~(~i_id_float & (i_id_rt == REG_ZERO));

    assign o_load_use = i_ex_load & i_ex_rwrite
                      & (i_ex_float == i_id_float)
                      & (w_rs_hit | w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Load-use / multi-cycle FPU stall and redirect flush controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FPU_LAT = FPU_LAT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_float,
    input  logic             id_fpu_multi,
    input  logic             id_redirect,
    input  logic             ex_load,
    input  logic             ex_rwrite,
    input  logic [4:0]       ex_dst,
    input  logic             ex_float,
    input  logic             ex_dw,
    output logic             stall_enable,
    output logic             flush_idex,
    output logic             flush_ifid,
    output logic             fpu_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [FPU_CNT_W-1:0] C_FPU_LOAD = FPU_CNT_W'(FPU_LAT - 1);

    hz_state_t            r_state;
    hz_state_t            w_state_nxt;
    logic [FPU_CNT_W-1:0] r_fpu_cnt;
    logic [FPU_CNT_W-1:0] w_fpu_cnt_nxt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 w_lu;
    logic                 w_stall;

    hazard_detect u_hazard_detect (
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .i_id_float   (id_float),
        .i_ex_load    (ex_load),
        .i_ex_rwrite  (ex_rwrite),
        .i_ex_dst     (ex_dst),
        .i_ex_float   (ex_float),
        .i_ex_dw      (ex_dw),
        .o_load_use   (w_lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fpu_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fpu_cnt <= w_fpu_cnt_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_fpu_cnt_nxt = r_fpu_cnt;
        w_stall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_lu) begin
                    w_stall = 1'b1;
                end else if (id_fpu_multi) begin
                    w_stall       = 1'b1;
                    w_fpu_cnt_nxt = C_FPU_LOAD;
                    w_state_nxt   = ST_FPU_WAIT;
                end
            end
            ST_FPU_WAIT: begin
                w_stall       = 1'b1;
                w_fpu_cnt_nxt = r_fpu_cnt - 1'b1;
                if (r_fpu_cnt == FPU_CNT_W'(1)) begin
                    w_state_nxt = ST_FPU_RELEASE;
                end
            end
            ST_FPU_RELEASE: begin
                // The op leaves ID this cycle, so its multi flag is ignored.
                w_stall     = w_lu;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset overrides every combinational term.
    assign stall_enable = rst_n & w_stall;
    assign flush_idex   = rst_n & w_stall;
    assign flush_ifid   = rst_n & id_redirect & ~w_stall;
    assign fpu_busy     = rst_n & (r_state == ST_FPU_WAIT);
    assign stall_count  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_float;
    logic        id_fpu_multi;
    logic        id_redirect;
    logic        ex_load;
    logic        ex_rwrite;
    logic [4:0]  ex_dst;
    logic        ex_float;
    logic        ex_dw;
    logic        stall_enable;
    logic        flush_idex;
    logic        flush_ifid;
    logic        fpu_busy;
    logic [15:0] stall_count;

    int n_vec;
    int n_err;

    pipeline_hazard_ctrl #(
        .FPU_LAT (4),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_float     (id_float),
        .id_fpu_multi (id_fpu_multi),
        .id_redirect  (id_redirect),
        .ex_load      (ex_load),
        .ex_rwrite    (ex_rwrite),
        .ex_dst       (ex_dst),
        .ex_float     (ex_float),
        .ex_dw        (ex_dw),
        .stall_enable (stall_enable),
        .flush_idex   (flush_idex),
        .flush_ifid   (flush_ifid),
        .fpu_busy     (fpu_busy),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic se, input logic fi,
                           input logic ff, input logic fb);
        chk({tag, ".stall"},      {31'd0, stall_enable}, {31'd0, se});
        chk({tag, ".flush_idex"}, {31'd0, flush_idex},   {31'd0, fi});
        chk({tag, ".flush_ifid"}, {31'd0, flush_ifid},   {31'd0, ff});
        chk({tag, ".fpu_busy"},   {31'd0, fpu_busy},     {31'd0, fb});
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_float = 1'b0;
        id_fpu_multi = 1'b0; id_redirect = 1'b0;
        ex_load = 1'b0; ex_rwrite = 1'b0; ex_dst = 5'd0; ex_float = 1'b0; ex_dw = 1'b0;
    endtask

    task automatic load_ex(input logic [4:0] dst, input logic fl, input logic dw);
        ex_load = 1'b1; ex_rwrite = 1'b1; ex_dst = dst; ex_float = fl; ex_dw = dw;
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        load_ex(5'd5, 1'b0, 1'b0);
        id_rs = 5'd5;
        id_redirect = 1'b1;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.count", {16'd0, stall_count}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // Integer load-use on rs
        next_cycle();
        load_ex(5'd5, 1'b0, 1'b0); id_rs = 5'd5;
        #1;
        chk_out("lu_rs", 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        chk_out("lu_rs_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs.count", {16'd0, stall_count}, 32'd1);

        // r0 never matches; class mismatch never matches
        load_ex(5'd0, 1'b0, 1'b0); id_rs = 5'd0;
        #1;
        chk("r0.stall", {31'd0, stall_enable}, 32'd0);
        next_cycle();
        load_ex(5'd7, 1'b1, 1'b0); id_rs = 5'd7; id_float = 1'b0;
        #1;
        chk("class.stall", {31'd0, stall_enable}, 32'd0);

        // rt match only counts when rt is used
        next_cycle();
        idle_inputs();
        load_ex(5'd9, 1'b0, 1'b0); id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        chk("lu_rt.stall", {31'd0, stall_enable}, 32'd1);

        // Double write wraps 31+1 -> 0 for float pairs
        next_cycle();
        idle_inputs();
        load_ex(5'd31, 1'b1, 1'b1); id_float = 1'b1; id_rs = 5'd10; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        chk("dw.stall", {31'd0, stall_enable}, 32'd1);
        next_cycle();
        id_uses_rt = 1'b0;
        #1;
        chk("dw_nort.stall", {31'd0, stall_enable}, 32'd0);

        // Float register 0 is a real register
        next_cycle();
        idle_inputs();
        load_ex(5'd0, 1'b1, 1'b0); id_float = 1'b1; id_rs = 5'd0;
        #1;
        chk("f0.stall", {31'd0, stall_enable}, 32'd1);

        // Redirect under stall is held off, then resolves
        next_cycle();
        idle_inputs();
        load_ex(5'd12, 1'b0, 1'b0); id_rs = 5'd12; id_redirect = 1'b1;
        #1;
        chk_out("redir_lu", 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        idle_inputs();
        id_redirect = 1'b1;
        #1;
        chk_out("redir_go", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("redir.count", {16'd0, stall_count}, 32'd5);

        // Multi-cycle FPU op: 4 stall cycles, busy in cycles 2..4, then release
        next_cycle();
        idle_inputs();
        id_fpu_multi = 1'b1; id_float = 1'b1;
        #1;
        chk_out("fpu_c1", 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        chk_out("fpu_c2", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("fpu_c3", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("fpu_c4", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("fpu_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fpu.count", {16'd0, stall_count}, 32'd9);
        next_cycle();
        id_fpu_multi = 1'b0;
        #1;
        chk("fpu_idle.stall", {31'd0, stall_enable}, 32'd0);

        // Reset during FPU_WAIT abandons the sequence
        next_cycle();
        id_fpu_multi = 1'b1;
        #1;
        chk("rst_c1.stall", {31'd0, stall_enable}, 32'd1);
        next_cycle();
        chk("rst_c2.busy", {31'd0, fpu_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.count", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rerun_c1", 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        chk_out("rerun_c2", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("rerun_c3", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("rerun_c4", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        chk_out("rerun_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rerun.count", {16'd0, stall_count}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
